// File: rtl/microwave_front_panel.sv
// Microwave front panel: synchronizes and debounces keypad/door inputs,
// turns key presses into controller pulses, holds entered time, drives done beep.
module microwave_front_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_raw,
    input  logic       key_stop_raw,
    input  logic       key_digit_raw,
    input  logic [3:0] key_digit,
    input  logic       door_sw_raw,
    input  logic       cooking,
    input  logic [3:0] remaining_time,
    output logic       start,
    output logic       stop,
    output logic       door_open,
    output logic       door_close,
    output logic [3:0] time_set,
    output logic       beep
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);
    // Bit order {door, digit, stop, start}; door path resets to "open".
    localparam logic [3:0] RST_LVL = 4'b1000;

    logic [3:0]          raw_w;
    logic [3:0]          s1_q;
    logic [3:0]          s2_q;
    logic [3:0]          lvl_q;
    logic [3:0]          lvl_d;
    logic [3:0][CW-1:0]  cnt_q;
    logic [3:0][CW-1:0]  cnt_d;
    logic [2:0]          prev_q;
    logic [2:0]          press_w;
    logic                stop_ev;
    logic                start_ev;
    logic                digit_ev;
    logic                start_ok;
    logic                done_w;
    logic [7:0]          n_w;
    logic                start_q;
    logic                start_d;
    logic                stop_q;
    logic                stop_d;
    logic [3:0]          ts_q;
    logic [3:0]          ts_d;
    logic                cook_prev_q;
    logic [BW-1:0]       beep_q;
    logic [BW-1:0]       beep_d;

    assign raw_w = {door_sw_raw, key_digit_raw, key_stop_raw, key_start_raw};

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                cnt_d[i] = '0;
                lvl_d[i] = ~lvl_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign press_w  = lvl_q[2:0] & ~prev_q;
    assign stop_ev  = press_w[1];
    assign start_ev = press_w[0] & ~press_w[1];
    assign digit_ev = press_w[2] & ~press_w[1] & ~press_w[0];
    assign start_ok = start_ev & ~lvl_q[3]
                    & ((ts_q != 4'd0) | (remaining_time != 4'd0));
    assign n_w      = {4'd0, ts_q} * 8'd10 + {4'd0, key_digit};
    assign done_w   = cook_prev_q & ~cooking & (remaining_time == 4'd0);

    always_comb begin
        start_d = start_ok;
        stop_d  = stop_ev & cooking;
        ts_d    = ts_q;
        // Clear one edge after the pulse: the controller has latched it by then.
        if (start_q) begin
            ts_d = 4'd0;
        end else if (stop_ev & ~cooking) begin
            ts_d = 4'd0;
        end else if (digit_ev & ~cooking & (key_digit <= 4'd9)) begin
            ts_d = (n_w <= 8'd15) ? n_w[3:0] : key_digit;
        end
    end

    always_comb begin
        beep_d = beep_q;
        if (|press_w) begin
            beep_d = '0;
        end else if (done_w) begin
            beep_d = BEEP_LOAD;
        end else if (beep_q != '0) begin
            beep_d = beep_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= RST_LVL;
            s2_q        <= RST_LVL;
            lvl_q       <= RST_LVL;
            cnt_q       <= '0;
            prev_q      <= 3'b000;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            ts_q        <= 4'd0;
            cook_prev_q <= 1'b0;
            beep_q      <= '0;
        end else begin
            s1_q        <= raw_w;
            s2_q        <= s1_q;
            lvl_q       <= lvl_d;
            cnt_q       <= cnt_d;
            prev_q      <= lvl_q[2:0];
            start_q     <= start_d;
            stop_q      <= stop_d;
            ts_q        <= ts_d;
            cook_prev_q <= cooking;
            beep_q      <= beep_d;
        end
    end

    assign start      = start_q;
    assign stop       = stop_q;
    assign door_open  = lvl_q[3];
    assign door_close = ~lvl_q[3];
    assign time_set   = ts_q;
    assign beep       = (beep_q != '0);

endmodule

// File: tb/tb_microwave_front_panel.sv
// Randomized scoreboard bench for microwave_front_panel.
// Stimulus tasks predict output events; a negedge monitor checks them.
module tb_microwave_front_panel;

    localparam int DEB  = 4;
    localparam int BEEP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_start_raw;
    logic       key_stop_raw;
    logic       key_digit_raw;
    logic [3:0] key_digit;
    logic       door_sw_raw;
    logic       cooking;
    logic [3:0] remaining_time;
    logic       start;
    logic       stop;
    logic       door_open;
    logic       door_close;
    logic [3:0] time_set;
    logic       beep;

    microwave_front_panel #(
        .DEBOUNCE_CYCLES(DEB),
        .BEEP_CYCLES    (BEEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_start_raw (key_start_raw),
        .key_stop_raw  (key_stop_raw),
        .key_digit_raw (key_digit_raw),
        .key_digit     (key_digit),
        .door_sw_raw   (door_sw_raw),
        .cooking       (cooking),
        .remaining_time(remaining_time),
        .start         (start),
        .stop          (stop),
        .door_open     (door_open),
        .door_close    (door_close),
        .time_set      (time_set),
        .beep          (beep)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int v;
    } exp_t;

    exp_t q_start[$];
    exp_t q_stop[$];
    exp_t q_ts[$];
    exp_t q_beep[$];
    exp_t q_door[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (what the panel should believe)
    int m_ts, m_door, m_cook, m_rem, m_brise, m_bend;

    task automatic chk(string nm, int ac, int ec, int av, int xv);
        n_cmp++;
        if (ac != ec || av != xv) begin
            n_bad++;
            $display("FAIL %s: got cyc=%0d val=%0d, want cyc=%0d val=%0d",
                     nm, ac, av, ec, xv);
        end
    endtask

    int p_ts, p_beep, p_door;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_ts   = time_set;
            p_beep = beep;
            p_door = door_open;
        end else begin
            if (start && stop) chk("start_stop_excl", 1, 0, 0, 0);
            if (start) begin
                if (q_start.size() == 0) chk("start_unexp", cyc, -1, 1, 0);
                else begin
                    e = q_start.pop_front();
                    chk("start", cyc, e.c, 1, 1);
                end
            end
            if (stop) begin
                if (q_stop.size() == 0) chk("stop_unexp", cyc, -1, 1, 0);
                else begin
                    e = q_stop.pop_front();
                    chk("stop", cyc, e.c, 1, 1);
                end
            end
            if (int'(time_set) != p_ts) begin
                if (q_ts.size() == 0) chk("ts_unexp", cyc, -1, time_set, p_ts);
                else begin
                    e = q_ts.pop_front();
                    chk("time_set", cyc, e.c, time_set, e.v);
                end
                p_ts = time_set;
            end
            if (int'(beep) != p_beep) begin
                if (q_beep.size() == 0) chk("beep_unexp", cyc, -1, beep, p_beep);
                else begin
                    e = q_beep.pop_front();
                    chk("beep", cyc, e.c, beep, e.v);
                end
                p_beep = beep;
            end
            if (int'(door_open) != p_door) begin
                if (q_door.size() == 0) chk("door_unexp", cyc, -1, door_open, p_door);
                else begin
                    e = q_door.pop_front();
                    chk("door", cyc, e.c, door_open * 2 + door_close,
                        e.v * 2 + (e.v == 0 ? 1 : 0));
                end
                p_door = door_open;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) step();
    endtask

    task automatic set_raw(int kind, logic v);
        case (kind)
            0: key_start_raw = v;
            1: key_stop_raw  = v;
            default: key_digit_raw = v;
        endcase
    endtask

    task automatic release_reset();
        step();
        rst = 1'b0;
        if (door_sw_raw == 1'b0) q_door.push_back('{cyc + DEB + 2, 0});
        m_door = door_sw_raw;
    endtask

    // kind: 0 start, 1 stop, 2 digit
    task automatic press(int kind, int d, int hold, bit bnc);
        int k0, ev, n, nv;
        exp_t tmp;
        step();
        key_digit = 4'(d);
        if (bnc) begin
            for (int s = 0; s < 4; s++) begin
                set_raw(kind, (s % 2) == 0);
                wait_cyc($urandom_range(1, DEB - 1));
            end
        end
        set_raw(kind, 1'b1);
        k0 = cyc;
        ev = k0 + DEB + 3;
        if (ev > m_brise && ev < m_bend) begin
            tmp = q_beep.pop_back();
            q_beep.push_back('{ev, 0});
            m_bend = ev;
        end
        if (kind == 1) begin
            if (m_cook != 0) q_stop.push_back('{ev, 1});
            else begin
                if (m_ts != 0) q_ts.push_back('{ev, 0});
                m_ts = 0;
            end
        end else if (kind == 0) begin
            if (m_door == 0 && (m_ts != 0 || m_rem != 0)) begin
                q_start.push_back('{ev, 1});
                if (m_ts != 0) q_ts.push_back('{ev + 1, 0});
                m_ts = 0;
            end
        end else if (m_cook == 0 && d <= 9) begin
            n  = m_ts * 10 + d;
            nv = (n <= 15) ? n : d;
            if (nv != m_ts) q_ts.push_back('{ev, nv});
            m_ts = nv;
        end
        wait_cyc(hold);
        set_raw(kind, 1'b0);
        wait_cyc(DEB + 6);
    endtask

    task automatic set_door(int v);
        step();
        door_sw_raw = v[0];
        if (v != m_door) q_door.push_back('{cyc + DEB + 2, v});
        m_door = v;
        wait_cyc(DEB + 6);
    endtask

    task automatic set_cooking(int c, int rem);
        step();
        cooking        = c[0];
        remaining_time = 4'(rem);
        if (m_cook != 0 && c == 0 && rem == 0) begin
            m_brise = cyc + 1;
            m_bend  = cyc + 1 + BEEP;
            q_beep.push_back('{m_brise, 1});
            q_beep.push_back('{m_bend, 0});
        end
        m_cook = c;
        m_rem  = rem;
    endtask

    initial begin
        int op;
        rst = 1'b1;
        key_start_raw = 0;
        key_stop_raw  = 0;
        key_digit_raw = 0;
        key_digit     = 0;
        door_sw_raw   = 0;
        cooking       = 0;
        remaining_time = 0;
        m_ts = 0; m_door = 1; m_cook = 0; m_rem = 0;
        m_brise = -1; m_bend = -1;

        wait_cyc(3);
        chk("rst_start", 0, 0, start, 0);
        chk("rst_stop", 0, 0, stop, 0);
        chk("rst_ts", 0, 0, time_set, 0);
        chk("rst_beep", 0, 0, beep, 0);
        chk("rst_door_open", 0, 0, door_open, 1);
        chk("rst_door_close", 0, 0, door_close, 0);

        release_reset();
        wait_cyc(DEB + 6);

        press(2, 1, DEB, 0);
        press(2, 2, DEB + 2, 0);
        press(2, 7, DEB, 0);
        press(2, 10, DEB + 1, 0);
        press(0, 0, DEB + 3, 1);

        press(2, 5, DEB, 0);
        set_door(1);
        press(0, 0, DEB, 0);
        set_door(0);
        press(0, 0, DEB, 0);

        set_cooking(1, 5);
        wait_cyc(2);
        press(1, 0, DEB, 0);
        press(2, 3, DEB, 0);
        set_cooking(0, 5);
        wait_cyc(BEEP + 2);
        press(2, 9, DEB, 0);
        press(1, 0, DEB, 0);
        press(0, 0, DEB, 0);

        set_cooking(1, 2);
        wait_cyc(2);
        set_cooking(0, 0);
        wait_cyc(BEEP + 3);
        set_cooking(1, 3);
        wait_cyc(2);
        set_cooking(0, 3);
        wait_cyc(BEEP + 3);

        set_cooking(1, 1);
        wait_cyc(2);
        set_cooking(0, 0);
        press(2, 4, DEB, 0);
        wait_cyc(BEEP);

        set_cooking(1, 1);
        wait_cyc(2);
        set_cooking(0, 0);
        wait_cyc(3);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_beep", 0, 0, beep, 0);
        chk("midrst_ts", 0, 0, time_set, 0);
        chk("midrst_door", 0, 0, door_open * 2 + door_close, 2);
        q_beep.delete();
        m_ts = 0; m_door = 1; m_cook = 0; m_rem = 0;
        m_brise = -1; m_bend = -1;
        wait_cyc(2);
        release_reset();
        wait_cyc(DEB + 6);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                press(2, $urandom_range(0, 12), $urandom_range(DEB, DEB + 5),
                      $urandom_range(0, 1) == 1);
            end else if (op == 5) begin
                press(0, 0, $urandom_range(DEB, DEB + 5), $urandom_range(0, 1) == 1);
            end else if (op == 6) begin
                press(1, 0, $urandom_range(DEB, DEB + 5), $urandom_range(0, 1) == 1);
            end else if (op == 7) begin
                set_door(m_door == 0 ? 1 : 0);
            end else begin
                set_cooking(m_cook == 0 ? 1 : 0, $urandom_range(0, 3));
                wait_cyc(BEEP + 3);
            end
        end

        wait_cyc(20);
        chk("drain_start", 0, 0, q_start.size(), 0);
        chk("drain_stop", 0, 0, q_stop.size(), 0);
        chk("drain_ts", 0, 0, q_ts.size(), 0);
        chk("drain_beep", 0, 0, q_beep.size(), 0);
        chk("drain_door", 0, 0, q_door.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
